// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the async FIFO write/read pointer controllers.
package fifo_pkg;

    localparam int FIFO_SIZE_DEFAULT = 4;
    localparam int AF_MARGIN_DEFAULT = 2;

    // Number of storage entries for a pointer of the given width (one extra wrap bit).
    function automatic int fifo_depth(input int size);
        return 1 << (size - 1);
    endfunction

endpackage

// File: rtl/fifo_level_calc.sv
// Combinational fill-level and flag computation from a leading and a lagging pointer.
// Write side: lead = next write pointer, lag = synchronised read pointer.
// Read side reuses it with the operands swapped.
module fifo_level_calc
    import fifo_pkg::*;
#(
    parameter int SIZE      = FIFO_SIZE_DEFAULT,
    parameter int AF_MARGIN = AF_MARGIN_DEFAULT
) (
    input  logic [SIZE-1:0] ptr_lead,
    input  logic [SIZE-1:0] ptr_lag,
    output logic [SIZE-1:0] lvl_nxt,
    output logic            full_nxt,
    output logic            af_nxt,
    output logic            illegal
);

    localparam logic [SIZE-1:0] DEPTH_V = SIZE'(fifo_depth(SIZE));
    localparam logic [SIZE-1:0] AF_TH   = SIZE'(fifo_depth(SIZE) - AF_MARGIN);

    // Modular distance between the pointers and the threshold compares on it.
    always_comb begin
        lvl_nxt  = ptr_lead - ptr_lag;
        full_nxt = (lvl_nxt >= DEPTH_V);
        af_nxt   = (lvl_nxt >= AF_TH);
        illegal  = (lvl_nxt > DEPTH_V);
    end

endmodule

// File: rtl/fifo_wr_ctrl.sv
// Write-side pointer and flag controller for the asynchronous FIFO.
// Optional build macro FIFO_WR_OVF_STICKY_EN: when defined, ovf latches on any
// dropped write or illegal level until rst; otherwise ovf is a one-cycle pulse.
module fifo_wr_ctrl
    import fifo_pkg::*;
#(
    parameter int SIZE      = FIFO_SIZE_DEFAULT,
    parameter int AF_MARGIN = AF_MARGIN_DEFAULT
) (
    input  logic            src_clk,
    input  logic            rst,
    input  logic            wr_en,
    input  logic [SIZE-1:0] rd_ptr_bin_sync,
    output logic [SIZE-1:0] wr_ptr_bin,
    output logic [SIZE-2:0] wr_addr,
    output logic            mem_we,
    output logic            full,
    output logic            almost_full,
    output logic [SIZE-1:0] level,
    output logic            ovf
);

    localparam logic [SIZE-1:0] DEPTH_V = SIZE'(fifo_depth(SIZE));

    logic [SIZE-1:0] wr_ptr_q, wr_ptr_d;
    logic [SIZE-1:0] level_q, level_d;
    logic            full_q, full_d;
    logic            af_q, af_d;
    logic            ovf_q, ovf_d;

    logic            wr_acc;
    logic            wr_drop;
    logic [SIZE-1:0] wr_ptr_nxt;
    logic [SIZE-1:0] lvl_nxt;
    logic            full_nxt;
    logic            af_nxt;
    logic            illegal;

    // Accept/drop decision and next pointer; writes are ignored while rst is high.
    always_comb begin
        wr_acc     = wr_en & ~full_q & ~rst;
        wr_drop    = wr_en & full_q;
        wr_ptr_nxt = wr_ptr_q + SIZE'(wr_acc);
    end

    fifo_level_calc #(
        .SIZE      (SIZE),
        .AF_MARGIN (AF_MARGIN)
    ) u_level_calc (
        .ptr_lead (wr_ptr_nxt),
        .ptr_lag  (rd_ptr_bin_sync),
        .lvl_nxt  (lvl_nxt),
        .full_nxt (full_nxt),
        .af_nxt   (af_nxt),
        .illegal  (illegal)
    );

    // Next-state for pointer, saturated level, flags and overflow indication.
    always_comb begin
        wr_ptr_d = wr_ptr_nxt;
        level_d  = illegal ? DEPTH_V : lvl_nxt;
        full_d   = full_nxt;
        af_d     = af_nxt;
`ifdef FIFO_WR_OVF_STICKY_EN
        ovf_d    = ovf_q | wr_drop | illegal;
`else
        ovf_d    = wr_drop | illegal;
`endif
    end

    // State registers, cleared asynchronously on rst.
    always_ff @(posedge src_clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            af_q     <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            level_q  <= level_d;
            full_q   <= full_d;
            af_q     <= af_d;
            ovf_q    <= ovf_d;
        end
    end

    assign wr_ptr_bin  = wr_ptr_q;
    assign wr_addr     = wr_ptr_q[SIZE-2:0];
    assign mem_we      = wr_acc;
    assign full        = full_q;
    assign almost_full = af_q;
    assign level       = level_q;
    assign ovf         = ovf_q;

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Directed bench for fifo_wr_ctrl with SIZE=4, DEPTH=8, AF_MARGIN=2.
module tb_fifo_wr_ctrl;

    localparam int SIZE = 4;
`ifdef FIFO_WR_OVF_STICKY_EN
    localparam logic STICKY = 1'b1;
`else
    localparam logic STICKY = 1'b0;
`endif

    logic            src_clk = 1'b0;
    logic            rst     = 1'b1;
    logic            wr_en   = 1'b0;
    logic [SIZE-1:0] rd_ptr_bin_sync = '0;
    logic [SIZE-1:0] wr_ptr_bin;
    logic [SIZE-2:0] wr_addr;
    logic            mem_we;
    logic            full;
    logic            almost_full;
    logic [SIZE-1:0] level;
    logic            ovf;

    int total = 0;
    int bad   = 0;

    fifo_wr_ctrl #(.SIZE(SIZE), .AF_MARGIN(2)) dut (
        .src_clk         (src_clk),
        .rst             (rst),
        .wr_en           (wr_en),
        .rd_ptr_bin_sync (rd_ptr_bin_sync),
        .wr_ptr_bin      (wr_ptr_bin),
        .wr_addr         (wr_addr),
        .mem_we          (mem_we),
        .full            (full),
        .almost_full     (almost_full),
        .level           (level),
        .ovf             (ovf)
    );

    always #5 src_clk = ~src_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge src_clk);
        #1;
    endtask

    task automatic chk_state(input string tag, input int ptr, input int lvl,
                             input logic f, input logic af, input logic ov);
        chk({tag, ".ptr"},  32'(wr_ptr_bin),  32'(ptr));
        chk({tag, ".lvl"},  32'(level),       32'(lvl));
        chk({tag, ".full"}, 32'(full),        32'(f));
        chk({tag, ".af"},   32'(almost_full), 32'(af));
        chk({tag, ".ovf"},  32'(ovf),         32'(ov));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        wr_en = 1'b0;
        rd_ptr_bin_sync = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        // Reset held with wr_en toggling
        tick();
        for (int i = 0; i < 4; i++) begin
            wr_en = ~wr_en;
            #1;
            chk("rst.mem_we", 32'(mem_we), 0);
            tick();
            chk_state("rst", 0, 0, 1'b0, 1'b0, 1'b0);
        end
        wr_en = 1'b0;
        rst = 1'b0;

        // Fill: eight writes
        wr_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("fill.addr", 32'(wr_addr), 32'(i));
            chk("fill.we",   32'(mem_we),  1);
            tick();
            chk_state("fill", i + 1, i + 1, (i + 1) >= 8, (i + 1) >= 6, 1'b0);
        end
        // Ninth write dropped
        chk("drop.we", 32'(mem_we), 0);
        tick();
        chk_state("drop", 8, 8, 1'b1, 1'b1, 1'b1);
        wr_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("idle.ovf", 32'(ovf), 32'(STICKY));
        end
        // Async reset clears ovf without a clock edge
        rst = 1'b1;
        #1;
        chk_state("rst_mid", 0, 0, 1'b0, 1'b0, 1'b0);
        tick();
        rst = 1'b0;

        // Wrap: rd at 8, writes carry pointer 8 -> 15 -> 0
        wr_en = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        chk_state("wrap.pre", 8, 8, 1'b1, 1'b1, 1'b0);
        wr_en = 1'b0;
        rd_ptr_bin_sync = 4'd8;
        tick();
        chk_state("wrap.rd8", 8, 0, 1'b0, 1'b0, 1'b0);
        wr_en = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        chk_state("wrap.p15", 15, 7, 1'b0, 1'b1, 1'b0);
        chk("wrap.we", 32'(mem_we), 1);
        tick();
        chk_state("wrap.p0", 0, 8, 1'b1, 1'b1, 1'b0);
        chk("wrap.addr", 32'(wr_addr), 0);

        // Simultaneous read advance and write while full
        rd_ptr_bin_sync = 4'd9;
        #1;
        chk("sim.we", 32'(mem_we), 0);
        tick();
        chk_state("sim.drop", 0, 7, 1'b0, 1'b1, 1'b1);
        chk("sim.we2", 32'(mem_we), 1);
        tick();
        chk_state("sim.acc", 1, 8, 1'b1, 1'b1, STICKY);
        wr_en = 1'b0;

        // Illegal sync pointer
        do_reset();
        wr_en = 1'b1;
        tick();
        tick();
        wr_en = 1'b0;
        chk_state("ill.pre", 2, 2, 1'b0, 1'b0, 1'b0);
        rd_ptr_bin_sync = 4'd9;
        tick();
        chk_state("ill.hit", 2, 8, 1'b1, 1'b1, 1'b1);
        rd_ptr_bin_sync = 4'd0;
        tick();
        chk_state("ill.rec", 2, 2, 1'b0, 1'b0, STICKY);
        rst = 1'b1;
        #1;
        chk("ill.rst_ovf", 32'(ovf), 0);
        tick();
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_wr_ctrl.md
Name: fifo_wr_ctrl

Overview:
- Write-side pointer and flag controller for the asynchronous FIFO.
- Sits directly upstream of the pointer-crossing transmitter:
  - drives the binary write pointer that the transmitter gray-codes and synchronises into the read domain;
  - consumes the read pointer that the read-side transmitter has already synchronised and converted back to binary.
- Generates memory write address/enable, full, almost_full, fill level and overflow indication in the write clock domain.

Parameters:
- SIZE, 4, pointer width in bits. Address width is SIZE-1. DEPTH = 2^(SIZE-1). Legal range SIZE >= 2.
- AF_MARGIN, 2, almost_full asserts when level >= DEPTH - AF_MARGIN. Legal range 0..DEPTH-1.

Ports:
- src_clk  in  1  write-domain clock.
- rst  in  1  asynchronous, active-high reset.
- wr_en  in  1  write request from producer.
- rd_ptr_bin_sync  in  SIZE  read pointer, binary, already synchronised into src_clk domain.
- wr_ptr_bin  out  SIZE  registered binary write pointer; goes to transmitter signal_in.
- wr_addr  out  SIZE-1  memory write address = wr_ptr_bin[SIZE-2:0].
- mem_we  out  1  memory write enable = wr_en & ~full (combinational).
- full  out  1  registered full flag.
- almost_full  out  1  registered almost-full flag.
- level  out  SIZE  registered fill count, 0..DEPTH.
- ovf  out  1  overflow indication (see Optional Feature).

Behaviour:
- One clock, src_clk; reset is asynchronous and active-high on rst.
- Reset (asynchronous assert, released on clock): wr_ptr_bin=0, full=0, almost_full=0, level=0, ovf=0. mem_we=0 follows because wr_en is ignored while rst is high.
- Accept rule:
  - wr_acc = wr_en & ~full.
  - A write while full is dropped: pointer does not move and mem_we=0.
- Pointer:
  - wr_ptr_nxt = wr_ptr_bin + wr_acc, mod 2^SIZE. Wraps 2^SIZE-1 -> 0; the MSB toggles on every DEPTH writes.
  - wr_ptr_bin updates on the src_clk rising edge.
  - Latency: the memory write happens in the same cycle as wr_en. The pointer and flags reflect it in the next cycle.
- Level:
  - lvl_nxt = (wr_ptr_nxt - rd_ptr_bin_sync) mod 2^SIZE, unsigned, SIZE bits.
  - Registered into level every cycle, including cycles with no write, so read-side progress is tracked.
- Flags, registered from lvl_nxt:
  - full <= (lvl_nxt >= DEPTH).
  - almost_full <= (lvl_nxt >= DEPTH-AF_MARGIN).
  - full implies almost_full.
- Pessimism: rd_ptr_bin_sync lags the true read pointer by the synchroniser delay. level and full may over-report, never under-report. This is the intended behaviour.
- Illegal lvl_nxt > DEPTH (corrupt or non-monotonic sync pointer): full=1, level saturates to DEPTH, and ovf pulses for one cycle even without the macro.
- Simultaneous write and read-pointer advance in the same cycle: both feed lvl_nxt. level stays unchanged, full does not assert.
- Full and wr_en in the same cycle: write dropped, overflow event raised (see Optional Feature).
- Reset mid-operation: all state clears immediately. Any in-flight write in that cycle is lost.

Optional Feature:
- Macro: FIFO_WR_OVF_STICKY_EN.
- Defined:
  - ovf is sticky; set on any dropped write (wr_en & full) or illegal level.
  - Cleared only by rst.
- Undefined:
  - ovf is a registered one-cycle pulse, asserted the cycle after each dropped write or illegal level.

Decomposition:
- Shared package fifo_pkg:
  - FIFO_SIZE_DEFAULT=4 and AF_MARGIN_DEFAULT=2;
  - function fifo_depth(size) returning 2^(size-1);
  - enum-free constants reused by the read-side controller (fifo_rd_ctrl).
- One sub-module: fifo_level_calc. Purely combinational: wr_ptr_nxt and rd_ptr_bin_sync in; lvl_nxt, full_nxt, af_nxt and illegal out. The read side reuses it with the operands swapped.

Test Plan (SIZE=4, DEPTH=8, AF_MARGIN=2, rd_ptr_bin_sync=0 unless stated):
- Reset: rst=1 with wr_en=1 toggling -> all outputs 0, mem_we=0. After release and one write, wr_ptr_bin=1, level=1.
- Fill: 8 consecutive wr_en cycles -> wr_addr 0..7. almost_full=1 after the 6th write, full=1 after the 8th, level=8. A 9th wr_en gives mem_we=0, wr_ptr_bin stays 8, ovf=1.
- Wrap: rd_ptr_bin_sync steps to 8 while writing continues until wr_ptr_bin=15, then writes one more -> wr_ptr_bin=0, wr_addr=0, level=(0-8) mod 16=8, full=1.
- Simultaneous: level=8/full; rd_ptr_bin_sync +1 and wr_en in the same cycle -> the write is dropped that cycle (full registered), level=7 and full=0 next cycle. The following write is accepted, level=8.
- Illegal: wr_ptr_bin=2, force rd_ptr_bin_sync=9 (lvl=9) -> full=1, level=8, ovf pulse.
- Macro: dropped write then 5 idle cycles -> ovf held 1 with FIFO_WR_OVF_STICKY_EN, single-cycle pulse without it. rst clears ovf in both builds.
